// File: rtl/fft8_frame_loader.sv
// Serial-to-parallel frame loader for the 8-point FFT: packs complex samples into
// ping-pong banks, presents a completed bank on x0..x7 and handshakes it with the FFT.
module fft8_frame_loader #(
   parameter int DATA_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_real,
   input  logic signed [DATA_W-1:0] in_imag,
   input  logic                     in_last,
   input  logic                     fft_valid,
   output logic                     start,
   output logic signed [DATA_W-1:0] x0_real,
   output logic signed [DATA_W-1:0] x1_real,
   output logic signed [DATA_W-1:0] x2_real,
   output logic signed [DATA_W-1:0] x3_real,
   output logic signed [DATA_W-1:0] x4_real,
   output logic signed [DATA_W-1:0] x5_real,
   output logic signed [DATA_W-1:0] x6_real,
   output logic signed [DATA_W-1:0] x7_real,
   output logic signed [DATA_W-1:0] x0_imag,
   output logic signed [DATA_W-1:0] x1_imag,
   output logic signed [DATA_W-1:0] x2_imag,
   output logic signed [DATA_W-1:0] x3_imag,
   output logic signed [DATA_W-1:0] x4_imag,
   output logic signed [DATA_W-1:0] x5_imag,
   output logic signed [DATA_W-1:0] x6_imag,
   output logic signed [DATA_W-1:0] x7_imag,
   output logic                     busy,
   output logic                     short_frame
);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

   state_t                   r_state;
   state_t                   w_state_next;
   logic signed [DATA_W-1:0] r_mem_re [2][8];
   logic signed [DATA_W-1:0] r_mem_im [2][8];
   logic [1:0]               r_full;
   logic [1:0]               w_full_next;
   logic                     r_wr_bank;
   logic                     r_rd_bank;
   logic [2:0]               r_wr_idx;
   logic                     r_short;
   logic                     w_accept;
   logic                     w_close;
   logic                     w_release;

   assign in_ready  = ~r_full[r_wr_bank];
   assign w_accept  = in_valid & in_ready;
   assign w_close   = w_accept & (in_last | (r_wr_idx == 3'd7));
   assign w_release = (r_state == ST_WAIT) & fft_valid;

   // Writing entry 0 also clears entries 1..7, so an early close leaves a zero-padded tail.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < 2; b++) begin
            for (int e = 0; e < 8; e++) begin
               r_mem_re[b][e] <= '0;
               r_mem_im[b][e] <= '0;
            end
         end
      end else if (w_accept) begin
         for (int e = 0; e < 8; e++) begin
            if (r_wr_idx == 3'(e)) begin
               r_mem_re[r_wr_bank][e] <= in_real;
               r_mem_im[r_wr_bank][e] <= in_imag;
            end else if (r_wr_idx == 3'd0) begin
               r_mem_re[r_wr_bank][e] <= '0;
               r_mem_im[r_wr_bank][e] <= '0;
            end
         end
      end
   end

   // Close and release always target different banks, so both may apply at one edge.
   always_comb begin
      w_full_next = r_full;
      if (w_close) begin
         w_full_next[r_wr_bank] = 1'b1;
      end
      if (w_release) begin
         w_full_next[r_rd_bank] = 1'b0;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (r_full[r_rd_bank]) w_state_next = ST_ISSUE;
         ST_ISSUE: w_state_next = ST_WAIT;
         ST_WAIT:  if (fft_valid) w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_full    <= 2'b00;
         r_wr_bank <= 1'b0;
         r_rd_bank <= 1'b0;
         r_wr_idx  <= 3'd0;
         r_short   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_full  <= w_full_next;
         r_short <= w_close & (r_wr_idx != 3'd7);
         if (w_close) begin
            r_wr_bank <= ~r_wr_bank;
            r_wr_idx  <= 3'd0;
         end else if (w_accept) begin
            r_wr_idx <= r_wr_idx + 3'd1;
         end
         if (w_release) begin
            r_rd_bank <= ~r_rd_bank;
         end
      end
   end

   assign start       = (r_state == ST_ISSUE);
   assign busy        = (r_state != ST_IDLE);
   assign short_frame = r_short;

   assign x0_real = r_mem_re[r_rd_bank][0];
   assign x1_real = r_mem_re[r_rd_bank][1];
   assign x2_real = r_mem_re[r_rd_bank][2];
   assign x3_real = r_mem_re[r_rd_bank][3];
   assign x4_real = r_mem_re[r_rd_bank][4];
   assign x5_real = r_mem_re[r_rd_bank][5];
   assign x6_real = r_mem_re[r_rd_bank][6];
   assign x7_real = r_mem_re[r_rd_bank][7];
   assign x0_imag = r_mem_im[r_rd_bank][0];
   assign x1_imag = r_mem_im[r_rd_bank][1];
   assign x2_imag = r_mem_im[r_rd_bank][2];
   assign x3_imag = r_mem_im[r_rd_bank][3];
   assign x4_imag = r_mem_im[r_rd_bank][4];
   assign x5_imag = r_mem_im[r_rd_bank][5];
   assign x6_imag = r_mem_im[r_rd_bank][6];
   assign x7_imag = r_mem_im[r_rd_bank][7];

endmodule

// File: tb/tb_fft8_frame_loader.sv
// Scoreboard bench for fft8_frame_loader: a frame-level model predicts frames, in_ready,
// short_frame and start timing; a negedge monitor checks each issued frame while busy.
module tb_fft8_frame_loader;

   typedef logic [7:0][15:0] vec_t;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic signed [15:0] in_real = '0;
   logic signed [15:0] in_imag = '0;
   logic               in_last = 1'b0;
   logic               fft_valid = 1'b0;
   logic               start;
   logic               busy;
   logic               short_frame;
   logic signed [15:0] x0_real, x1_real, x2_real, x3_real, x4_real, x5_real, x6_real, x7_real;
   logic signed [15:0] x0_imag, x1_imag, x2_imag, x3_imag, x4_imag, x5_imag, x6_imag, x7_imag;
   vec_t               dut_re;
   vec_t               dut_im;

   fft8_frame_loader #(.DATA_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_real(in_real), .in_imag(in_imag), .in_last(in_last), .fft_valid(fft_valid),
      .start(start),
      .x0_real(x0_real), .x1_real(x1_real), .x2_real(x2_real), .x3_real(x3_real),
      .x4_real(x4_real), .x5_real(x5_real), .x6_real(x6_real), .x7_real(x7_real),
      .x0_imag(x0_imag), .x1_imag(x1_imag), .x2_imag(x2_imag), .x3_imag(x3_imag),
      .x4_imag(x4_imag), .x5_imag(x5_imag), .x6_imag(x6_imag), .x7_imag(x7_imag),
      .busy(busy), .short_frame(short_frame)
   );

   always #5 clk = ~clk;

   assign dut_re = {x7_real, x6_real, x5_real, x4_real, x3_real, x2_real, x1_real, x0_real};
   assign dut_im = {x7_imag, x6_imag, x5_imag, x4_imag, x3_imag, x2_imag, x1_imag, x0_imag};

   int   n_checks = 0;
   int   n_fail = 0;
   vec_t exp_re_q[$];
   vec_t exp_im_q[$];
   vec_t part_re;
   vec_t part_im;
   int   part_n;
   int   outstanding;
   int   cd;
   int   step_no = 0;
   int   hold_until = 0;
   int   fft_delay = 3;
   bit   force_fft = 0;
   int   exp_start_at;
   bit   pend_short;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      part_re = '0;
      part_im = '0;
      part_n = 0;
      outstanding = 0;
      cd = -1;
      exp_re_q.delete();
      exp_im_q.delete();
      exp_start_at = -1;
      pend_short = 0;
   endtask

   // One clock of stimulus: check model predictions, act as the FFT, drive the next inputs.
   task automatic step(input bit v, input logic [15:0] re, input logic [15:0] im,
                       input bit last, output bit acc);
      bit exp_ready;
      bit fv;
      bit close;
      @(negedge clk);
      step_no++;
      exp_ready = (outstanding < 2);
      chk("in_ready", in_ready, exp_ready);
      chk("short_frame", short_frame, pend_short);
      pend_short = 0;
      if (start) begin
         if (exp_start_at >= 0) chk("start_latency", step_no, exp_start_at);
         else chk("start_unexpected", start, 0);
         exp_start_at = -1;
         cd = fft_delay;
      end else if (exp_start_at >= 0 && step_no > exp_start_at) begin
         chk("start_missing", start, 1);
         exp_start_at = -1;
      end
      fv = 0;
      if (cd == 0 && step_no >= hold_until) begin
         fv = 1;
         cd = -1;
         outstanding--;
         if (outstanding == 1) exp_start_at = step_no + 2;
      end else if (cd > 0) begin
         cd--;
      end
      if (force_fft) fv = 1;
      fft_valid = fv;
      in_valid = v;
      in_real = re;
      in_imag = im;
      in_last = last;
      acc = v && exp_ready;
      if (acc) begin
         part_re[part_n] = re;
         part_im[part_n] = im;
         close = last || (part_n == 7);
         if (close) begin
            pend_short = (part_n < 7);
            exp_re_q.push_back(part_re);
            exp_im_q.push_back(part_im);
            if (outstanding == 0) exp_start_at = step_no + 2;
            outstanding++;
            part_re = '0;
            part_im = '0;
            part_n = 0;
         end else begin
            part_n++;
         end
      end
   endtask

   task automatic send(input logic [15:0] re, input logic [15:0] im, input bit last);
      bit acc;
      int tries = 0;
      do begin
         step(1'b1, re, im, last, acc);
         tries++;
      end while (!acc && tries < 200);
      if (!acc) chk("send_timeout", acc, 1);
   endtask

   task automatic drain();
      bit acc;
      int n = 0;
      while ((outstanding > 0 || exp_re_q.size() > 0) && n < 300) begin
         step(1'b0, 16'd0, 16'd0, 1'b0, acc);
         n++;
      end
      chk("drain_outstanding", outstanding, 0);
      chk("drain_frames_left", exp_re_q.size(), 0);
      repeat (3) step(1'b0, 16'd0, 16'd0, 1'b0, acc);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      #1;
      rst = 1'b1;
      in_valid = 1'b0;
      in_last = 1'b0;
      fft_valid = 1'b0;
      model_clear();
      repeat (n) begin
         @(negedge clk);
         chk("rst_x_real", dut_re, '0);
         chk("rst_x_imag", dut_im, '0);
         chk("rst_start", start, 0);
         chk("rst_busy", busy, 0);
         chk("rst_in_ready", in_ready, 1);
         chk("rst_short", short_frame, 0);
      end
      rst = 1'b0;
   endtask

   // Monitor: pops a frame at each start and holds the outputs to it until release.
   vec_t cur_re;
   vec_t cur_im;
   bit   have_cur = 0;
   logic prev_start = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         have_cur <= 0;
      end else begin
         if (start) begin
            chk("start_back_to_back", prev_start, 0);
            if (exp_re_q.size() == 0) begin
               chk("start_no_frame", start, 0);
            end else begin
               cur_re = exp_re_q.pop_front();
               cur_im = exp_im_q.pop_front();
               have_cur = 1;
            end
         end
         if (busy && have_cur) begin
            chk("x_real", dut_re, cur_re);
            chk("x_imag", dut_im, cur_im);
         end
      end
      prev_start <= start;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      model_clear();
      do_reset(3);

      // single frame 1..8 / -1..-8
      fft_delay = 5;
      for (int i = 1; i <= 8; i++) send(16'(i), 16'(-i), 1'b0);
      drain();

      // ping-pong with the FFT withholding completion for 30 cycles
      fft_delay = 2;
      hold_until = step_no + 30;
      for (int i = 1; i <= 24; i++) send(16'(i), 16'(i + 1000), 1'b0);
      drain();
      hold_until = 0;

      // short frame closed by in_last
      send(16'd5, 16'd50, 1'b0);
      send(16'd6, 16'd60, 1'b0);
      send(16'd7, 16'd70, 1'b1);
      drain();

      // reset mid-stream discards a partial frame
      for (int i = 10; i < 14; i++) send(16'(i), 16'(-i), 1'b0);
      do_reset(3);
      for (int i = 100; i < 108; i++) send(16'(i), 16'(i + 7), 1'b0);
      drain();

      // spurious fft_valid while idle
      force_fft = 1;
      repeat (4) step(1'b0, 16'd0, 16'd0, 1'b0, acc);
      force_fft = 0;
      repeat (3) step(1'b0, 16'd0, 16'd0, 1'b0, acc);

      // randomized traffic with random gaps, short frames and FFT delays
      for (int i = 0; i < 200; i++) begin
         fft_delay = int'($urandom_range(1, 6));
         if ($urandom_range(0, 4) == 0) step(1'b0, 16'($urandom), 16'($urandom), 1'b0, acc);
         send(16'($urandom), 16'($urandom), ($urandom_range(0, 7) == 0));
      end
      if (part_n != 0) send(16'($urandom), 16'($urandom), 1'b1);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fft8_frame_loader.md
# fft8_frame_loader

Upstream feeder for the 8-point FFT core. Accepts a serial stream of complex Q15 samples over a valid/ready handshake, packs them into 8-sample frames in a two-bank (ping-pong) buffer, presents a completed frame as parallel `x0..x7` real/imag words and issues a one-cycle `start` to the FFT. It holds each frame stable until the FFT reports `valid`, while the other bank fills.

## Interface
- `DATA_W`, default 16: sample component width, signed; must match the FFT input width.
- `clk`  in  1  rising-edge clock, single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  sample present on `in_real`/`in_imag`.
- `in_ready`  out  1  loader can accept a sample this cycle.
- `in_real`, `in_imag`  in  DATA_W each  signed sample components.
- `in_last`  in  1  marks final sample of a frame; qualified by `in_valid & in_ready`.
- `fft_valid`  in  1  FFT completion pulse, connected to FFT `valid`.
- `start`  out  1  one-cycle FFT start pulse.
- `x0_real..x7_real`, `x0_imag..x7_imag`  out  DATA_W each  frame held for the FFT; index k = k-th accepted sample.
- `busy`  out  1  FFT frame outstanding (state ≠ IDLE).
- `short_frame`  out  1  one-cycle pulse when a frame is closed early by `in_last`.

## Operation
- Storage: two banks of 8 complex entries. Each bank has a `full` flag. Pointers: `wr_bank`, `wr_idx` (3 bits), `rd_bank`.
- `in_ready` = !full[wr_bank]. This is combinational from registered state; `in_valid` is not used to generate it.
- A sample is accepted when `in_valid & in_ready` at an edge. It is written to `bank[wr_bank][wr_idx]`.
- Frame close happens on an accepted sample with `wr_idx==7` or `in_last==1`:
  - full[wr_bank]<=1, wr_bank toggles, wr_idx<=0.
  - If closed at wr_idx=k<7: entries k+1..7 of that bank read as zero (zero-pad), and `short_frame` pulses in the next cycle.
  - `in_last` at idx 7 is a normal close with no `short_frame`.
- Otherwise an accepted sample increments wr_idx.
- Outputs `x*` always show bank[rd_bank]. A full bank is never written, so the outputs are stable from `start` until release.
- Issue FSM has three states:
  - IDLE: if full[rd_bank], go to ISSUE.
  - ISSUE: `start`=1 for this cycle only, go to WAIT.
  - WAIT: on `fft_valid`=1, full[rd_bank]<=0, rd_bank toggles, go to IDLE.
- `fft_valid` in IDLE or ISSUE is ignored.
- Fill and release are independent. A frame close and a bank release may occur at the same edge; both take effect.
- No arithmetic. Data is passed through bit-exact at DATA_W.

## Timing
- Reset values:
  - `start`=0, `busy`=0, `short_frame`=0, all `x*`=0, `in_ready`=1.
  - Both banks zeroed, full=00, wr_bank=rd_bank=0, wr_idx=0, FSM=IDLE.
- Reset asserted mid-frame or mid-FFT discards all buffered data. No `start` is issued for the discarded data.
- Sustained throughput is 1 sample/cycle while a bank is free.
- Latency: closing sample accepted at edge E → FSM in ISSUE after E+1 → `start` high for the cycle between E+1 and E+2 (FFT samples it at E+2). This assumes the FSM was IDLE before E.
- Release: `fft_valid` high at edge D in WAIT → FSM in IDLE and bank freed after D.
  - If the other bank is full: ISSUE after D+1, next `start` high between D+1 and D+2.
  - If the loader was stalled (both banks full), `in_ready` rises after D.
- `start` is never high in two consecutive cycles. Minimum spacing between `start` pulses is 3 cycles.
- `busy` is high from ISSUE through the cycle ending at the releasing edge D.

## Test plan
- Reset: hold `rst` 3 cycles mid-stream → all `x*`=0, `start`=0, `busy`=0, `in_ready`=1.
- Single frame: stream real 1..8, imag −1..−8 back-to-back. Then `start` pulses once, 2 edges after the 8th sample. `x0_real`=1 … `x7_real`=8 and `x7_imag`=−8 stay stable until `fft_valid`.
- Ping-pong/backpressure: 24 consecutive samples (values 1..24), `fft_valid` withheld 30 cycles:
  - samples 1..16 accepted;
  - `in_ready`=0 on the 17th;
  - after `fft_valid`, second `start` with `x0_real`=9 … `x7_real`=16, and `in_ready` returns.
- Short frame: samples 5,6,7 with `in_last` on 7 → `short_frame` pulse, `x0..x2_real`=5,6,7, `x3..x7`=0, `start` issued.
- Reset after 4 of 8 samples, then 8 fresh samples 100..107 → exactly one `start` with `x0_real`=100 … `x7_real`=107.
- Spurious `fft_valid` while IDLE, and `in_valid` asserted while `in_ready`=0 → no state change, no data written, no `start`.
